// File: rtl/uart_core.sv
// uart_core: 8N1 UART engine with a 16x oversampled receiver and an independently timed transmitter
module uart_core #(
   parameter int freq_hz = 50000000,
   parameter int baud    = 115200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_busy
);
   localparam int DIV = freq_hz / (baud * 16);
   localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
   localparam int BW  = $clog2(16 * DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
   localparam logic [BW-1:0] BIT_MAX = BW'(16 * DIV - 1);
   localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_WAITHI = 3'd4;
   localparam logic [0:0] TX_IDLE = 1'b0, TX_SEND = 1'b1;

   if (DIV < 1) begin : g_div_check
      $error("uart_core: freq_hz/(baud*16) must be at least 1");
   end

   logic [DW-1:0] div_q, div_d;
   logic [1:0]    sync_q;
   logic [2:0]    rx_st_q, rx_st_d;
   logic [3:0]    tck_q, tck_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    rsh_q, rsh_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_avail_q, rx_avail_d, rx_error_q, rx_error_d;
   logic [0:0]    tx_st_q, tx_st_d;
   logic [BW-1:0] btim_q, btim_d;
   logic [3:0]    bcnt_q, bcnt_d;
   logic [9:0]    tsh_q, tsh_d;
   logic          tick, rxs, bit_wrap;

   assign tick     = div_q == DIV_MAX;
   assign rxs      = sync_q[1];
   assign bit_wrap = btim_q == BIT_MAX;
   assign uart_txd = tsh_q[0];
   assign tx_busy  = tx_st_q == TX_SEND;
   assign rx_data  = rx_data_q;
   assign rx_avail = rx_avail_q;
   assign rx_error = rx_error_q;

   always_comb begin
      div_d      = tick ? '0 : div_q + 1'b1;
      rx_st_d    = rx_st_q;
      tck_d      = tck_q;
      idx_d      = idx_q;
      rsh_d      = rsh_q;
      rx_data_d  = rx_data_q;
      rx_avail_d = rx_avail_q & ~rx_ack;
      rx_error_d = rx_error_q & ~rx_ack;
      case (rx_st_q)
         RX_IDLE: if (tick && !rxs) begin
            rx_st_d = RX_START;
            tck_d   = '0;
         end
         RX_START: if (tick) begin
            tck_d = tck_q + 1'b1;
            if (tck_q == 4'd7) begin
               rx_st_d = rxs ? RX_IDLE : RX_DATA;
               tck_d   = '0;
               idx_d   = '0;
            end
         end
         RX_DATA: if (tick) begin
            tck_d = tck_q + 1'b1;
            if (tck_q == 4'd15) begin
               rsh_d[idx_q] = rxs;
               idx_d        = idx_q + 1'b1;
               rx_st_d      = idx_q == 3'd7 ? RX_STOP : RX_DATA;
            end
         end
         RX_STOP: if (tick) begin
            tck_d = tck_q + 1'b1;
            if (tck_q == 4'd15) begin
               // a completed frame overrides a coincident rx_ack
               rx_data_d  = rxs ? rsh_q : rx_data_q;
               rx_avail_d = rxs | rx_avail_d;
               rx_error_d = ~rxs;
               rx_st_d    = rxs ? RX_IDLE : RX_WAITHI;
            end
         end
         RX_WAITHI: rx_st_d = rxs ? RX_IDLE : RX_WAITHI;
         default: rx_st_d = RX_IDLE;
      endcase
   end

   always_comb begin
      tx_st_d = tx_st_q;
      btim_d  = bit_wrap ? '0 : btim_q + 1'b1;
      bcnt_d  = bcnt_q;
      tsh_d   = tsh_q;
      if (tx_st_q == TX_IDLE) begin
         if (tx_wr) begin
            tsh_d   = {1'b1, tx_data, 1'b0};
            btim_d  = '0;
            bcnt_d  = '0;
            tx_st_d = TX_SEND;
         end
      end else if (bit_wrap) begin
         tsh_d   = {1'b1, tsh_q[9:1]};
         bcnt_d  = bcnt_q + 1'b1;
         tx_st_d = bcnt_q == 4'd9 ? TX_IDLE : TX_SEND;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_q      <= '0;
         sync_q     <= 2'b11;
         rx_st_q    <= RX_IDLE;
         tck_q      <= '0;
         idx_q      <= '0;
         rsh_q      <= '0;
         rx_data_q  <= '0;
         rx_avail_q <= 1'b0;
         rx_error_q <= 1'b0;
         tx_st_q    <= TX_IDLE;
         btim_q     <= '0;
         bcnt_q     <= '0;
         tsh_q      <= '1;
      end else begin
         div_q      <= div_d;
         sync_q     <= {sync_q[0], uart_rxd};
         rx_st_q    <= rx_st_d;
         tck_q      <= tck_d;
         idx_q      <= idx_d;
         rsh_q      <= rsh_d;
         rx_data_q  <= rx_data_d;
         rx_avail_q <= rx_avail_d;
         rx_error_q <= rx_error_d;
         tx_st_q    <= tx_st_d;
         btim_q     <= btim_d;
         bcnt_q     <= bcnt_d;
         tsh_q      <= tsh_d;
      end
   end
endmodule

// File: doc/uart_core.md
# uart_core

Serial engine behind the Wishbone UART register block: converts 8N1 serial frames on `uart_rxd` into bytes and bytes into frames on `uart_txd`. It exposes a byte-level handshake to the bus wrapper:

- receive side: `rx_data`, `rx_avail`, `rx_error`, `rx_ack`
- transmit side: `tx_data`, `tx_wr`, `tx_busy`

The receiver uses 16x oversampling with mid-bit sampling. The transmitter has its own bit timer, restarted on every load.

## Interface
- `freq_hz`, default 50000000: clock frequency in Hz.
- `baud`, default 115200: line rate. The derived constant is DIV = freq_hz/(baud*16), integer truncation. DIV must be ≥1; elaboration fails otherwise.
- `clk`  in  1  system clock; the block has exactly one clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `uart_rxd`  in  1  asynchronous serial input; idle high.
- `uart_txd`  out  1  serial output; idle high.
- `rx_data`  out  8  last correctly framed received byte.
- `rx_avail`  out  1  an unread byte is present in `rx_data`.
- `rx_error`  out  1  the last frame had a bad stop bit.
- `rx_ack`  in  1  one-cycle pulse: consumer has read `rx_data`.
- `tx_data`  in  8  byte to send; sampled when `tx_wr`=1.
- `tx_wr`  in  1  one-cycle load strobe.
- `tx_busy`  out  1  a transmit frame is in progress.

## Operation
**Reset** (`reset_n`=0 at a clk edge), effective the next cycle:
- Outputs: `uart_txd`=1, `tx_busy`=0, `rx_avail`=0, `rx_error`=0, `rx_data`=0.
- Both FSMs go to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame. No partial byte is delivered.

**Oversample tick**
- Free-running counter 0..DIV-1; `tick` is high for one clk when the counter wraps.
- Used by the receiver only.

**Receiver**
- `uart_rxd` passes through a 2-flop synchronizer, giving `rxs`.
- FSM states: IDLE, START, DATA, STOP, WAITHI.
- IDLE: on a tick with `rxs`=0, go to START and clear the tick count.
- START: count 8 ticks, then sample `rxs`.
  - 0: go to DATA with bit index 0.
  - 1: glitch; return to IDLE.
- DATA: every 16 ticks, sample `rxs` into shift register bit[index]. Data is LSB first. After index 7, go to STOP.
- STOP: after 16 ticks, sample `rxs`.
  - 1 (good frame): in one cycle set `rx_data`←shift, `rx_avail`←1, `rx_error`←0; go to IDLE.
  - 0 (framing error): `rx_error`←1; `rx_data`/`rx_avail` unchanged; go to WAITHI.
- WAITHI: stay until `rxs`=1, then go to IDLE. A held break therefore produces exactly one error.
- `rx_ack`=1 clears `rx_avail` and `rx_error` in the next cycle.
- Good-frame completion in the same cycle as `rx_ack`: completion wins; `rx_avail` stays 1 and holds the new byte.
- Overrun: a new good frame while `rx_avail`=1 overwrites `rx_data`. No overrun flag exists.

**Transmitter**
- FSM states: IDLE, SEND.
- Frame shift register is 10 bits: {1, `tx_data`, 0}, sent LSB first.
- IDLE, `tx_wr`=1:
  - Load the shift register and set `tx_busy`←1.
  - Clear the bit timer; it counts 0..16*DIV-1.
  - Go to SEND.
- `tx_wr` while `tx_busy`=1 is ignored; no effect on the current frame.
- SEND: `uart_txd` = shreg[0]. On each bit-timer wrap, shift right. After the 10th wrap: `tx_busy`←0, `uart_txd`=1, go to IDLE.

## Timing
- Bit period: 16*DIV clks. For the defaults, DIV=27, so the bit period is 432 clks and one frame is 4320 clks.
- TX latency:
  - `uart_txd` falls and `tx_busy` rises in the cycle after the `tx_wr` edge.
  - `tx_busy` is high for exactly 10*16*DIV cycles.
  - A `tx_wr` in the first cycle `tx_busy`=0 is accepted (back-to-back frames, no idle gap).
- RX latency:
  - Sample points: START at 8 ticks (mid start bit); each DATA bit at 16 ticks after the previous sample; STOP 16 ticks after bit 7. The stop sample is therefore at 9.5 bit periods after the detected start.
  - Falling edge at the pin → start detection: 2 clks of synchronizer plus ≤DIV clks of tick alignment.
  - `rx_avail` rises 1 clk after the stop sample tick.
  - Tolerance: ±DIV clks of sample jitter.
- `rx_ack` → `rx_avail` low: 1 clk.
- Combinational paths from inputs to outputs: none. All outputs are registered.

## Test plan
Bench parameters: freq_hz=3200000, baud=100000, giving DIV=2 and a bit period of 32 clks.

1. Reset: hold `reset_n`=0 with `uart_rxd` toggling → `uart_txd`=1, `tx_busy`=0, `rx_avail`=0, `rx_error`=0, `rx_data`=0x00.
2. TX 0xA5: pulse `tx_wr` → `uart_txd` shows 0,1,0,1,0,0,1,0,1,1 for 32 clks each; `tx_busy` high for exactly 320 clks. A second `tx_wr` (0x00) at cycle 100 is ignored.
3. RX 0x3C, good stop bit → `rx_data`=0x3C and `rx_avail`=1 about 304 clks after the start edge; `rx_ack` pulse → `rx_avail`=0 next cycle.
4. RX with stop bit 0, then line held low for 1000 clks, then 0x55 sent → exactly one `rx_error`=1 and `rx_avail` stays 0. After 0x55: `rx_data`=0x55, `rx_avail`=1, `rx_error`=0.
5. Start glitch: 10-clk low pulse → no state change, `rx_avail`=0. Next, two frames 0x11 then 0x22 with no ack → `rx_data`=0x22, `rx_avail`=1. `rx_ack` coinciding with completion of a third frame 0x33 → `rx_avail` stays 1, `rx_data`=0x33.
6. Reset mid-frame: assert `reset_n`=0 during TX bit 4 and during RX bit 3 → `uart_txd`=1 next cycle, no byte delivered; a subsequent 0x81 frame transmits and receives correctly.
